// File: rtl/csa_stream_accumulator_if.sv
// Operand/result handshake bundle for csa_stream_accumulator.
// The master side feeds operands and consumes results; the slave side is the accumulator.
interface csa_stream_accumulator_if #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16
);
  localparam int OUT_W = WIDTH + $clog2(MAX_OPS);
  localparam int CNT_W = $clog2(MAX_OPS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_overflow;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand accumulator: carry-save folding of one operand per cycle,
// then a chunked ripple adder resolves the (sum, carry) pair CHUNK bits per cycle.
module csa_stream_accumulator #(
  parameter int WIDTH   = 8,
  parameter int MAX_OPS = 16,
  parameter int CHUNK   = 4
) (
  input  logic clk,
  input  logic rst,
  csa_stream_accumulator_if.slave io
);
  localparam int OUT_W = WIDTH + $clog2(MAX_OPS);
  localparam int CNT_W = $clog2(MAX_OPS + 1);
  localparam int R     = (OUT_W + CHUNK - 1) / CHUNK;
  localparam int PAD_W = R * CHUNK;
  localparam int K_W   = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_e;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] s_q, s_d, c_q, c_d, x;
  logic [PAD_W-1:0] res_q, res_d, s_pad, c_pad;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             cin_q, cin_d;
  logic [CHUNK:0]   chunk_sum;
  logic             accept, deliver;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(MAX_OPS)) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (accept && io.in_last) state_d = RESOLVE;
      RESOLVE: if (k_q == K_W'(R - 1))   state_d = OUTPUT;
      OUTPUT:  if (deliver)              state_d = ACCUM;
      default:                           state_d = ACCUM;
    endcase
  end

  always_comb begin
    io.in_ready  = (state_q == ACCUM);
    io.out_valid = (state_q == OUTPUT);
  end

  assign accept          = io.in_valid && io.in_ready;
  assign deliver         = io.out_valid && io.out_ready;
  assign io.out_sum      = res_q[OUT_W-1:0];
  assign io.out_count    = cnt_q;
  assign io.out_overflow = ovf_q;

  // Accumulate stage: 3:2 compression, no carry propagation
  assign x     = OUT_W'(io.in_data);
  assign s_pad = PAD_W'(s_q);
  assign c_pad = PAD_W'(c_q);

  // Resolve stage: one CHUNK-wide slice of S + C per cycle, carry rippled through cin_q
  assign chunk_sum = {1'b0, s_pad[k_q*CHUNK +: CHUNK]}
                   + {1'b0, c_pad[k_q*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, cin_q};

  always_comb begin
    s_d   = s_q;
    c_d   = c_q;
    res_d = res_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    k_d   = k_q;
    cin_d = cin_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          s_d   = s_q ^ c_q ^ x;
          c_d   = ((s_q & c_q) | (s_q & x) | (c_q & x)) << 1;
          cnt_d = sat_inc(cnt_q);
          ovf_d = ovf_q | (cnt_q == CNT_W'(MAX_OPS));
          if (io.in_last) begin
            k_d   = '0;
            cin_d = 1'b0;
          end
        end
      end
      RESOLVE: begin
        res_d[k_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        cin_d = chunk_sum[CHUNK];
        k_d   = k_q + K_W'(1);
      end
      OUTPUT: begin
        if (deliver) begin
          s_d   = '0;
          c_d   = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          k_d   = '0;
          cin_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Register boundary: everything clears on reset so a partial group is discarded
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      c_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      k_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      c_q   <= c_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      k_q   <= k_d;
      cin_q <= cin_d;
    end
  end
endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Bench for csa_stream_accumulator: directed scenarios on the default build and
// randomized groups on CHUNK=1 / CHUNK=12 builds against an integer-sum model.
module tb_csa_stream_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int sel   = 0;

  logic       r_valid  = 1'b0;
  logic       r_last   = 1'b0;
  logic       r_oready = 1'b0;
  logic [7:0] r_data   = 8'd0;

  logic        m_iready, m_ovalid, m_ovf;
  logic [11:0] m_sum;
  logic [4:0]  m_cnt;

  csa_stream_accumulator_if #(.WIDTH(8), .MAX_OPS(16)) if0 ();
  csa_stream_accumulator_if #(.WIDTH(8), .MAX_OPS(16)) if1 ();
  csa_stream_accumulator_if #(.WIDTH(8), .MAX_OPS(16)) if2 ();

  csa_stream_accumulator #(.WIDTH(8), .MAX_OPS(16), .CHUNK(4))
    dut0 (.clk(clk), .rst(rst), .io(if0.slave));
  csa_stream_accumulator #(.WIDTH(8), .MAX_OPS(16), .CHUNK(1))
    dut1 (.clk(clk), .rst(rst), .io(if1.slave));
  csa_stream_accumulator #(.WIDTH(8), .MAX_OPS(16), .CHUNK(12))
    dut2 (.clk(clk), .rst(rst), .io(if2.slave));

  // Stimulus goes to the selected instance only; the others sit idle.
  always_comb begin
    if0.in_valid  = r_valid && (sel == 0);
    if0.in_data   = r_data;
    if0.in_last   = r_last;
    if0.out_ready = r_oready && (sel == 0);
    if1.in_valid  = r_valid && (sel == 1);
    if1.in_data   = r_data;
    if1.in_last   = r_last;
    if1.out_ready = r_oready && (sel == 1);
    if2.in_valid  = r_valid && (sel == 2);
    if2.in_data   = r_data;
    if2.in_last   = r_last;
    if2.out_ready = r_oready && (sel == 2);
  end

  always_comb begin
    m_iready = if0.in_ready;
    m_ovalid = if0.out_valid;
    m_sum    = if0.out_sum;
    m_cnt    = if0.out_count;
    m_ovf    = if0.out_overflow;
    if (sel == 1) begin
      m_iready = if1.in_ready;
      m_ovalid = if1.out_valid;
      m_sum    = if1.out_sum;
      m_cnt    = if1.out_count;
      m_ovf    = if1.out_overflow;
    end else if (sel == 2) begin
      m_iready = if2.in_ready;
      m_ovalid = if2.out_valid;
      m_sum    = if2.out_sum;
      m_cnt    = if2.out_count;
      m_ovf    = if2.out_overflow;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    r_valid = 1'b1;
    r_data  = d;
    r_last  = l;
    step();
    r_valid = 1'b0;
    r_last  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!m_ovalid && lat < 40) begin
      step();
      lat++;
    end
    if (!m_ovalid) lat = -1;
  endtask

  task automatic take();
    r_oready = 1'b1;
    step();
    r_oready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      tests++;
      if ({m_iready, m_ovalid, m_sum, m_cnt, m_ovf} !== {1'b1, 1'b0, 12'd0, 5'd0, 1'b0}) begin
        fails++;
        $display("FAIL reset_state[%0d]: got rdy=%b vld=%b sum=%0d cnt=%0d ovf=%b want rdy=1 vld=0 sum=0 cnt=0 ovf=0",
                 i, m_iready, m_ovalid, m_sum, m_cnt, m_ovf);
      end
    end
    sel = 0;
    #1;
  endtask

  task automatic test_basic();
    int lat;
    send(8'd3, 1'b0);
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    wait_valid(lat);
    tests++;
    if (lat !== 3) begin
      fails++;
      $display("FAIL basic_latency: got %0d want 3", lat);
    end
    tests++;
    if ({m_sum, m_cnt, m_ovf} !== {12'd15, 5'd3, 1'b0}) begin
      fails++;
      $display("FAIL basic_result: got sum=%0d cnt=%0d ovf=%b want sum=15 cnt=3 ovf=0", m_sum, m_cnt, m_ovf);
    end
    take();
    tests++;
    if (m_ovalid !== 1'b0 || m_iready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release: got vld=%b rdy=%b want vld=0 rdy=1", m_ovalid, m_iready);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int rdy = 0;
    for (int i = 0; i < 16; i++) begin
      if (m_iready === 1'b1) rdy++;
      send(8'd255, i == 15);
    end
    tests++;
    if (rdy !== 16) begin
      fails++;
      $display("FAIL b2b_ready_cycles: got %0d want 16", rdy);
    end
    wait_valid(lat);
    tests++;
    if ({m_sum, m_cnt, m_ovf} !== {12'd4080, 5'd16, 1'b0}) begin
      fails++;
      $display("FAIL b2b_result: got sum=%0d cnt=%0d ovf=%b want sum=4080 cnt=16 ovf=0", m_sum, m_cnt, m_ovf);
    end
    take();
  endtask

  task automatic test_overflow();
    int lat;
    for (int i = 0; i < 17; i++) send(8'd255, i == 16);
    wait_valid(lat);
    tests++;
    if ({m_sum, m_cnt, m_ovf} !== {12'd239, 5'd16, 1'b1}) begin
      fails++;
      $display("FAIL overflow_result: got sum=%0d cnt=%0d ovf=%b want sum=239 cnt=16 ovf=1", m_sum, m_cnt, m_ovf);
    end
    take();
  endtask

  task automatic test_hold();
    int lat;
    int good = 0;
    send(8'd200, 1'b1);
    wait_valid(lat);
    for (int i = 0; i < 6; i++) begin
      if (m_ovalid === 1'b1 && m_sum === 12'd200 && m_iready === 1'b0) good++;
      if (i < 5) step();
    end
    tests++;
    if (good !== 6) begin
      fails++;
      $display("FAIL hold_stable_cycles: got %0d want 6", good);
    end
    take();
    send(8'd1, 1'b0);
    send(8'd1, 1'b1);
    wait_valid(lat);
    tests++;
    if ({m_sum, m_cnt, m_ovf} !== {12'd2, 5'd2, 1'b0}) begin
      fails++;
      $display("FAIL hold_next_group: got sum=%0d cnt=%0d ovf=%b want sum=2 cnt=2 ovf=0", m_sum, m_cnt, m_ovf);
    end
    take();
  endtask

  task automatic test_reset_mid();
    int lat;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    r_valid = 1'b1;
    r_data  = 8'd4;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
    r_valid = 1'b0;
    tests++;
    if (m_iready !== 1'b1 || m_ovalid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_state: got rdy=%b vld=%b want rdy=1 vld=0", m_iready, m_ovalid);
    end
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    wait_valid(lat);
    tests++;
    if ({m_sum, m_cnt, m_ovf} !== {12'd30, 5'd2, 1'b0}) begin
      fails++;
      $display("FAIL midreset_group: got sum=%0d cnt=%0d ovf=%b want sum=30 cnt=2 ovf=0", m_sum, m_cnt, m_ovf);
    end
    take();
    send(8'd99, 1'b1);
    wait_valid(lat);
    r_oready = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    r_oready = 1'b0;
    tests++;
    if ({m_iready, m_ovalid, m_sum, m_cnt} !== {1'b1, 1'b0, 12'd0, 5'd0}) begin
      fails++;
      $display("FAIL outreset_state: got rdy=%b vld=%b sum=%0d cnt=%0d want rdy=1 vld=0 sum=0 cnt=0",
               m_iready, m_ovalid, m_sum, m_cnt);
    end
  endtask

  task automatic test_random(input int which, input int exp_lat);
    int lat, n, acc, stall;
    logic [7:0]  d;
    logic [11:0] exp_sum;
    logic [4:0]  exp_cnt;
    logic        exp_ovf;
    sel = which;
    #1;
    for (int g = 0; g < 8; g++) begin
      n   = $urandom_range(1, 20);
      acc = 0;
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          r_valid = 1'b0;
          r_last  = 1'($urandom_range(0, 1));
          r_data  = 8'($urandom);
          step();
        end
        d   = 8'($urandom);
        acc = acc + int'(d);
        send(d, i == n - 1);
      end
      exp_sum = 12'(acc % 4096);
      exp_cnt = 5'((n > 16) ? 16 : n);
      exp_ovf = (n > 16);
      wait_valid(lat);
      tests++;
      if (lat !== exp_lat) begin
        fails++;
        $display("FAIL rand%0d_latency[%0d]: got %0d want %0d", which, g, lat, exp_lat);
      end
      stall = $urandom_range(0, 3);
      repeat (stall) step();
      tests++;
      if ({m_ovalid, m_sum, m_cnt, m_ovf} !== {1'b1, exp_sum, exp_cnt, exp_ovf}) begin
        fails++;
        $display("FAIL rand%0d_result[%0d]: got vld=%b sum=%0d cnt=%0d ovf=%b want vld=1 sum=%0d cnt=%0d ovf=%b",
                 which, g, m_ovalid, m_sum, m_cnt, m_ovf, exp_sum, exp_cnt, exp_ovf);
      end
      take();
    end
    sel = 0;
    #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_hold();
    test_reset_mid();
    test_random(0, 3);
    test_random(1, 12);
    test_random(2, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
